// File: rtl/next_kb_hotkey.sv
// NeXT keyboard events to OSSC menu commands: modifier-gated hotkeys, menu mode, valid/ready output.
// Optional auto-repeat of arrow keys is enabled by defining NEXT_HOTKEY_REPEAT_EN.
module next_kb_hotkey #(
  parameter logic [7:0]  HOTKEY_MOD       = 8'h18,
  parameter int unsigned REPEAT_DELAY_CYC = 13500000,
  parameter int unsigned REPEAT_RATE_CYC  = 2700000,
  parameter int unsigned CNT_W            = 24
) (
  input  logic        clk27,
  input  logic        hw_reset,
  input  logic [15:0] latest_keycode,
  input  logic        latest_keycode_valid,
  output logic [2:0]  cmd_code,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        menu_active,
  output logic        cmd_overflow
);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_OK    = 3'd5;
  localparam logic [2:0] CMD_BACK  = 3'd6;
  localparam logic [2:0] CMD_MENU  = 3'd7;

  logic [15:0] kc_q;
  logic        vld_q, vld_prev_q;
  logic [2:0]  cmd_code_q;
  logic        cmd_valid_q, cmd_overflow_q, menu_q;

  // Valid history resets high so a strobe already high across reset must drop before it counts.
  always_ff @(posedge clk27 or posedge hw_reset) begin
    if (hw_reset) begin
      kc_q       <= '0;
      vld_q      <= 1'b1;
      vld_prev_q <= 1'b1;
    end else begin
      kc_q       <= latest_keycode;
      vld_q      <= latest_keycode_valid;
      vld_prev_q <= vld_q;
    end
  end

  logic       key_event, brk, hot, is_esc, make_menu;
  logic [6:0] code;
  logic [2:0] key_cmd, make_cmd, issue_cmd;

  assign key_event = vld_q & ~vld_prev_q;
  assign brk       = kc_q[7];
  assign code      = kc_q[6:0];
  assign hot       = (kc_q[15:8] & HOTKEY_MOD) == HOTKEY_MOD;
  assign is_esc    = (code == 7'h49);

  always_comb begin
    key_cmd = CMD_NONE;
    case (code)
      7'h16:   key_cmd = CMD_UP;
      7'h0F:   key_cmd = CMD_DOWN;
      7'h09:   key_cmd = CMD_LEFT;
      7'h10:   key_cmd = CMD_RIGHT;
      7'h2A:   key_cmd = CMD_OK;
      default: key_cmd = CMD_NONE;
    endcase
  end

  always_comb begin
    make_cmd  = CMD_NONE;
    make_menu = 1'b0;
    if (key_event && !brk) begin
      if (is_esc) begin
        if (hot) begin
          make_cmd  = CMD_MENU;
          make_menu = 1'b1;
        end else if (menu_q) begin
          make_cmd = CMD_BACK;
        end
      end else if (key_cmd != CMD_NONE && (hot || menu_q)) begin
        make_cmd = key_cmd;
      end
    end
  end

`ifdef NEXT_HOTKEY_REPEAT_EN
  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       held_code_q;
  logic [2:0]       held_cmd_q, rep_cmd;
  logic             repeatable, held_break, still_hot;

  assign repeatable = make_cmd inside {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
  assign held_break = key_event && brk && (code == held_code_q);
  assign still_hot  = menu_q || hot;

  // A repeat fires only when no event in this cycle takes precedence.
  always_comb begin
    rep_cmd = CMD_NONE;
    if (state_q != StIdle && !held_break && make_cmd == CMD_NONE &&
        cnt_q == '0 && still_hot) begin
      rep_cmd = held_cmd_q;
    end
  end

  always_ff @(posedge clk27 or posedge hw_reset) begin
    if (hw_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      held_code_q <= '0;
      held_cmd_q  <= CMD_NONE;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (repeatable) begin
            held_code_q <= code;
            held_cmd_q  <= make_cmd;
            cnt_q       <= CNT_W'(REPEAT_DELAY_CYC - 1);
            state_q     <= StHeld;
          end
        end
        StHeld, StRepeat: begin
          if (held_break) begin
            state_q <= StIdle;
          end else if (repeatable) begin
            held_code_q <= code;
            held_cmd_q  <= make_cmd;
            cnt_q       <= CNT_W'(REPEAT_DELAY_CYC - 1);
            state_q     <= StHeld;
          end else if (make_cmd != CMD_NONE) begin
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            if (still_hot) begin
              cnt_q   <= CNT_W'(REPEAT_RATE_CYC - 1);
              state_q <= StRepeat;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign issue_cmd = (make_cmd != CMD_NONE) ? make_cmd : rep_cmd;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY_CYC[0], REPEAT_RATE_CYC[0], CNT_W[0]};
  assign issue_cmd = make_cmd;
`endif

  // A new command may load in the same cycle the pending one is accepted.
  always_ff @(posedge clk27 or posedge hw_reset) begin
    if (hw_reset) begin
      cmd_code_q     <= CMD_NONE;
      cmd_valid_q    <= 1'b0;
      cmd_overflow_q <= 1'b0;
      menu_q         <= 1'b0;
    end else begin
      if (make_menu) menu_q <= ~menu_q;
      if (issue_cmd != CMD_NONE) begin
        if (!cmd_valid_q || cmd_ready) begin
          cmd_code_q  <= issue_cmd;
          cmd_valid_q <= 1'b1;
        end else begin
          cmd_overflow_q <= 1'b1;
        end
      end else if (cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_code     = cmd_code_q;
  assign cmd_valid    = cmd_valid_q;
  assign cmd_overflow = cmd_overflow_q;
  assign menu_active  = menu_q;

endmodule

// File: tb/tb_next_kb_hotkey.sv
// Scoreboard bench for next_kb_hotkey: stimulus queues expected commands, a monitor pops on accept.
module tb_next_kb_hotkey;

  logic        clk27 = 1'b0;
  logic        hw_reset = 1'b1;
  logic [15:0] latest_keycode = '0;
  logic        latest_keycode_valid = 1'b0;
  logic [2:0]  cmd_code;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        menu_active;
  logic        cmd_overflow;

  next_kb_hotkey #(
    .HOTKEY_MOD      (8'h18),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_RATE_CYC (5),
    .CNT_W           (24)
  ) dut (
    .clk27               (clk27),
    .hw_reset            (hw_reset),
    .latest_keycode      (latest_keycode),
    .latest_keycode_valid(latest_keycode_valid),
    .cmd_code            (cmd_code),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .menu_active         (menu_active),
    .cmd_overflow        (cmd_overflow)
  );

  always #5 clk27 = ~clk27;

  int cyc = 0;
  always @(posedge clk27) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] code;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk27);
      #1;
    end
  endtask

  // One-cycle strobe; the expected command (if any) shows up two cycles after the strobe.
  task automatic send(input logic [15:0] kc, input logic [2:0] code, output int s);
    s = cyc;
    if (code != 3'd0) exp_q.push_back('{code: code, at: s + 2});
    latest_keycode = kc;
    latest_keycode_valid = 1'b1;
    tick();
    latest_keycode_valid = 1'b0;
    tick(2);
  endtask

  // Monitor: every accepted command is popped and checked for code and first-valid cycle.
  int   load_cyc = 0;
  logic was_valid = 1'b0;
  logic was_acc = 1'b0;
  always @(negedge clk27) begin
    exp_t e;
    if (cmd_valid === 1'b1 && (!was_valid || was_acc)) load_cyc = cyc;
    was_acc = 1'b0;
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      was_acc = 1'b1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_cmd: got code %0d at cycle %0d, want none", cmd_code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("cmd_code", 32'(cmd_code), 32'(e.code));
        check("cmd_cycle", 32'(load_cyc), 32'(e.at));
      end
    end
    was_valid = (cmd_valid === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int s, s2;

    // Reset state
    tick(2);
    check("rst_code", 32'(cmd_code), 0);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_menu", 32'(menu_active), 0);
    check("rst_ovf", 32'(cmd_overflow), 0);
    hw_reset = 1'b0;
    tick(2);
    check("post_rst_valid", 32'(cmd_valid), 0);

    // UP with both Command keys, held off by cmd_ready=0
    s = cyc;
    exp_q.push_back('{code: 3'd1, at: s + 2});
    latest_keycode = 16'h1816;
    latest_keycode_valid = 1'b1;
    tick();
    check("up_lat1_valid", 32'(cmd_valid), 0);
    latest_keycode_valid = 1'b0;
    tick();
    check("up_lat2_valid", 32'(cmd_valid), 1);
    check("up_lat2_code", 32'(cmd_code), 1);
    tick(3);
    check("up_hold_valid", 32'(cmd_valid), 1);
    check("up_hold_code", 32'(cmd_code), 1);
    cmd_ready = 1'b1;
    tick();
    check("up_clear", 32'(cmd_valid), 0);
    send(16'h1896, 3'd0, s);

    // Menu toggle, BACK in menu mode, toggle off
    send(16'h1849, 3'd7, s);
    check("menu_on", 32'(menu_active), 1);
    send(16'h0049, 3'd6, s);
    check("menu_still_on", 32'(menu_active), 1);
    send(16'h1849, 3'd7, s);
    check("menu_off", 32'(menu_active), 0);

    // No modifiers outside menu mode: ignored
    send(16'h000F, 3'd0, s);
    tick(30);
    check("nomod_valid", 32'(cmd_valid), 0);

    // Held RIGHT: repeats at +20/+25/+30 after the first, break stops it
    send(16'h1810, 3'd4, s);
`ifdef NEXT_HOTKEY_REPEAT_EN
    exp_q.push_back('{code: 3'd4, at: s + 22});
    exp_q.push_back('{code: 3'd4, at: s + 27});
    exp_q.push_back('{code: 3'd4, at: s + 32});
`endif
    while (cyc < s + 33) tick();
    send(16'h1890, 3'd0, s2);
    tick(40);

    // Overflow: second command while first is pending is dropped
    cmd_ready = 1'b0;
    send(16'h182A, 3'd5, s);
    send(16'h182A, 3'd0, s);
    check("ovf_code", 32'(cmd_code), 5);
    check("ovf_valid", 32'(cmd_valid), 1);
    check("ovf_flag", 32'(cmd_overflow), 1);
    cmd_ready = 1'b1;
    tick(3);

    // Reset in the middle of repeating with a command pending
    send(16'h1810, 3'd4, s);
`ifdef NEXT_HOTKEY_REPEAT_EN
    exp_q.push_back('{code: 3'd4, at: s + 22});
`endif
    while (cyc < s + 27) tick();
    cmd_ready = 1'b0;
`ifdef NEXT_HOTKEY_REPEAT_EN
    check("pre_rst_valid", 32'(cmd_valid), 1);
`endif
    hw_reset = 1'b1;
    latest_keycode = 16'h182A;
    latest_keycode_valid = 1'b1;
    #1;
    check("mid_rst_code", 32'(cmd_code), 0);
    check("mid_rst_valid", 32'(cmd_valid), 0);
    check("mid_rst_menu", 32'(menu_active), 0);
    check("mid_rst_ovf", 32'(cmd_overflow), 0);
    tick(2);
    hw_reset = 1'b0;
    tick(5);
    latest_keycode_valid = 1'b0;
    cmd_ready = 1'b1;
    tick(40);
    check("post_rst_ovf", 32'(cmd_overflow), 0);

    // New command loads in the same cycle the pending one is accepted
    cmd_ready = 1'b0;
    send(16'h182A, 3'd5, s);
    tick(2);
    s2 = cyc;
    exp_q.push_back('{code: 3'd1, at: s2 + 2});
    latest_keycode = 16'h1816;
    latest_keycode_valid = 1'b1;
    tick();
    latest_keycode_valid = 1'b0;
    cmd_ready = 1'b1;
    tick();
    check("same_cyc_code", 32'(cmd_code), 1);
    check("same_cyc_valid", 32'(cmd_valid), 1);
    check("same_cyc_ovf", 32'(cmd_overflow), 0);
    tick();
    send(16'h1896, 3'd0, s);
    tick(30);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
